// File: rtl/veerwolf_sw_reader.sv
// ============================================================================
// veerwolf_sw_reader
//
// Reads the board switches for the VeeRwolf SoC. This is the input-side
// counterpart of the LED output register and runs in the clk_core domain.
// It synchronizes the switch inputs and debounces them into a stable
// `state`. It also keeps sticky per-bit change flags (CHANGED) and raises a
// maskable level interrupt. The core reaches all of this through a small
// Wishbone slave.
//
// Build option:
//   VEERWOLF_SW_DEBOUNCE_EN  defined   -> prescaler plus per-bit debounce
//                                         counters filter the inputs.
//                            undefined -> state follows the synchronized
//                                         inputs every cycle.
//                                         DEBOUNCE_DIV and STABLE_TICKS
//                                         are ignored in this build.
//
// Parameters:
//   WIDTH         number of switch inputs (1..32)
//   DEBOUNCE_DIV  clk_core cycles per debounce sample tick (>= 2)
//   STABLE_TICKS  consecutive differing ticks needed to accept a level (1..15)
//
// Ports:
//   clk_core   core clock
//   rst_core   synchronous active-high reset
//   i_sw       asynchronous switch inputs
//   i_wb_adr   word address: 0 STATE, 1 CHANGED (W1C), 2 IRQ_EN, 3 RAW
//   i_wb_dat   write data
//   i_wb_we    write enable
//   i_wb_cyc   bus cycle
//   i_wb_stb   strobe
//   o_wb_rdt   registered read data, valid in the ack cycle
//   o_wb_ack   single-cycle acknowledge, one cycle after the request
//   o_irq      registered level interrupt, |(changed & irq_en)
// ============================================================================
module veerwolf_sw_reader #(
    parameter int WIDTH        = 16,
    parameter int DEBOUNCE_DIV = 1000,
    parameter int STABLE_TICKS = 4
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic [WIDTH-1:0] i_sw,
    input  logic [1:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    output logic             o_irq
);

    localparam logic [1:0] ADR_STATE   = 2'd0;
    localparam logic [1:0] ADR_CHANGED = 2'd1;
    localparam logic [1:0] ADR_IRQ_EN  = 2'd2;
    localparam logic [1:0] ADR_RAW     = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] clr_s;
    logic             ack_q, ack_d;
    logic             irq_q, irq_d;
    logic [31:0]      rdt_q, rdt_d;
    logic             req_s;

    // Only the low WIDTH bits of the write data are meaningful.
    logic unused_s;
    assign unused_s = ^i_wb_dat;

`ifdef VEERWOLF_SW_DEBOUNCE_EN
    localparam int              PW          = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST    = PW'(DEBOUNCE_DIV - 1);
    localparam logic [3:0]      STABLE_LAST = 4'(STABLE_TICKS - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_s;
    logic [3:0]    deb_q [WIDTH];
    logic [3:0]    deb_d [WIDTH];

    // Prescaler tick and per-bit debounce: a bit flips only after
    // STABLE_TICKS consecutive ticks that disagree with the current state.
    always_comb begin
        tick_s  = (pre_q == PRE_LAST);
        state_d = state_q;
        set_s   = {WIDTH{1'b0}};
        if (tick_s) begin
            pre_d = {PW{1'b0}};
        end else begin
            pre_d = pre_q + PW'(1);
        end
        for (int i = 0; i < WIDTH; i++) begin
            deb_d[i] = deb_q[i];
            if (tick_s) begin
                if (sync_q[i] != state_q[i]) begin
                    // Comparing with the pre-increment value means the
                    // counter "reaches" STABLE_TICKS on this tick.
                    if (deb_q[i] == STABLE_LAST) begin
                        deb_d[i]   = 4'd0;
                        state_d[i] = ~state_q[i];
                        set_s[i]   = 1'b1;
                    end else begin
                        deb_d[i] = deb_q[i] + 4'd1;
                    end
                end else begin
                    // Any agreeing tick discards a partial count, which
                    // rejects glitches shorter than STABLE_TICKS ticks.
                    deb_d[i] = 4'd0;
                end
            end else begin
                deb_d[i] = deb_q[i];
            end
        end
    end

    // Prescaler and debounce counter registers.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            pre_q <= {PW{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                deb_q[i] <= 4'd0;
            end
        end else begin
            pre_q <= pre_d;
            for (int i = 0; i < WIDTH; i++) begin
                deb_q[i] <= deb_d[i];
            end
        end
    end
`else
    // The debounce timing parameters have no effect in this build.
    localparam int cfg_unused = DEBOUNCE_DIV + STABLE_TICKS;

    // Without debounce, state tracks the synchronizer output one cycle
    // later. Every disagreement is also a change event.
    always_comb begin
        state_d = sync_q;
        set_s   = sync_q ^ state_q;
    end
`endif

    // Bus decode, sticky change flags, mask register, read mux, and irq.
    always_comb begin
        sync1_d = i_sw;
        sync_d  = sync1_q;
        // Accept a request only when no ack is outstanding. This limits
        // the bus to one transaction every other cycle.
        req_s   = i_wb_cyc & i_wb_stb & ~ack_q;
        ack_d   = req_s;

        if (req_s & i_wb_we & (i_wb_adr == ADR_CHANGED)) begin
            clr_s = i_wb_dat[WIDTH-1:0];
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
        // A set event in the same cycle as a W1C clear wins.
        changed_d = (changed_q & ~clr_s) | set_s;

        if (req_s & i_wb_we & (i_wb_adr == ADR_IRQ_EN)) begin
            irq_en_d = i_wb_dat[WIDTH-1:0];
        end else begin
            irq_en_d = irq_en_q;
        end

        rdt_d = rdt_q;
        if (req_s) begin
            rdt_d = 32'd0;
            case (i_wb_adr)
                ADR_STATE:   rdt_d[WIDTH-1:0] = state_q;
                ADR_CHANGED: rdt_d[WIDTH-1:0] = changed_q;
                ADR_IRQ_EN:  rdt_d[WIDTH-1:0] = irq_en_q;
                ADR_RAW:     rdt_d[WIDTH-1:0] = sync_q;
                default:     rdt_d = 32'd0;
            endcase
        end else begin
            rdt_d = rdt_q;
        end

        irq_d = |(changed_q & irq_en_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            sync1_q   <= {WIDTH{1'b0}};
            sync_q    <= {WIDTH{1'b0}};
            state_q   <= {WIDTH{1'b0}};
            changed_q <= {WIDTH{1'b0}};
            irq_en_q  <= {WIDTH{1'b0}};
            ack_q     <= 1'b0;
            rdt_q     <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync_q    <= sync_d;
            state_q   <= state_d;
            changed_q <= changed_d;
            irq_en_q  <= irq_en_d;
            ack_q     <= ack_d;
            rdt_q     <= rdt_d;
            irq_q     <= irq_d;
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_rdt = rdt_q;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_veerwolf_sw_reader.sv
// ============================================================================
// tb_veerwolf_sw_reader
//
// Directed self-checking bench for veerwolf_sw_reader with WIDTH=16,
// DEBOUNCE_DIV=4 and STABLE_TICKS=3. Expected values and timings are
// selected by VEERWOLF_SW_DEBOUNCE_EN, so the bench matches whichever
// build of the design it is compiled with.
// ============================================================================
module tb_veerwolf_sw_reader;

    localparam int WIDTH = 16;
    localparam logic [1:0] A_STATE   = 2'd0;
    localparam logic [1:0] A_CHANGED = 2'd1;
    localparam logic [1:0] A_IRQ_EN  = 2'd2;
    localparam logic [1:0] A_RAW     = 2'd3;
`ifdef VEERWOLF_SW_DEBOUNCE_EN
    localparam int SETTLE = 24;
`else
    localparam int SETTLE = 4;
`endif

    logic             clk_core = 1'b0;
    logic             rst_core = 1'b0;
    logic [WIDTH-1:0] i_sw     = 16'h0000;
    logic [1:0]       i_wb_adr = 2'd0;
    logic [31:0]      i_wb_dat = 32'd0;
    logic             i_wb_we  = 1'b0;
    logic             i_wb_cyc = 1'b0;
    logic             i_wb_stb = 1'b0;
    logic [31:0]      o_wb_rdt;
    logic             o_wb_ack;
    logic             o_irq;

    int   cmp_cnt = 0;
    int   err_cnt = 0;
    logic irq_at_ack = 1'b0;

    veerwolf_sw_reader #(
        .WIDTH        (WIDTH),
        .DEBOUNCE_DIV (4),
        .STABLE_TICKS (3)
    ) dut (
        .clk_core (clk_core),
        .rst_core (rst_core),
        .i_sw     (i_sw),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_we  (i_wb_we),
        .i_wb_cyc (i_wb_cyc),
        .i_wb_stb (i_wb_stb),
        .o_wb_rdt (o_wb_rdt),
        .o_wb_ack (o_wb_ack),
        .o_irq    (o_irq)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic [15:0] sw;
        logic [15:0] chg;
        logic [15:0] w1c;
        logic [15:0] chg_after;
        logic        irq;
    } vec_t;

    vec_t vecs [6];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_core);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One Wishbone transaction: request cycle, ack cycle, then one idle cycle.
    task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] wdat,
                       output logic [31:0] rdat);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = we;
        i_wb_adr = adr;
        i_wb_dat = wdat;
        @(posedge clk_core);
        #1;
        check("ack_pulse", {31'd0, o_wb_ack}, 32'd1);
        rdat       = o_wb_rdt;
        irq_at_ack = o_irq;
        i_wb_cyc   = 1'b0;
        i_wb_stb   = 1'b0;
        i_wb_we    = 1'b0;
        @(posedge clk_core);
        #1;
        check("ack_drop", {31'd0, o_wb_ack}, 32'd0);
    endtask

    task automatic rd(input logic [1:0] adr, input logic [31:0] exp, input string name);
        logic [31:0] d;
        bus(1'b0, adr, 32'd0, d);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] wdat);
        logic [31:0] d;
        bus(1'b1, adr, wdat, d);
    endtask

    task automatic do_reset();
        i_sw     = 16'h0000;
        rst_core = 1'b1;
        tick(2);
        rst_core = 1'b0;
    endtask

    // Reset, step the inputs, wait `dly` cycles, and read one register.
    task automatic probe(input logic [15:0] sw, input int dly, input logic [1:0] adr,
                         input logic [31:0] exp, input string name);
        do_reset();
        i_sw = sw;
        tick(dly);
        rd(adr, exp, name);
    endtask

    // Cycles after the call until o_irq first reads high (0 = never).
    task automatic poll_irq(output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (o_irq === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] d;

        // With IRQ_EN=0x00F0, each row below lists the switch value, the
        // sticky CHANGED value it should produce, a W1C mask, the CHANGED
        // value after the clear, and the expected interrupt.
        vecs[0] = '{sw: 16'h0005, chg: 16'h0005, w1c: 16'h0001, chg_after: 16'h0004, irq: 1'b0};
        vecs[1] = '{sw: 16'h0035, chg: 16'h0034, w1c: 16'h0000, chg_after: 16'h0034, irq: 1'b1};
        vecs[2] = '{sw: 16'h0031, chg: 16'h0034, w1c: 16'h0030, chg_after: 16'h0004, irq: 1'b0};
        vecs[3] = '{sw: 16'hA5A5, chg: 16'hA594, w1c: 16'hFFFF, chg_after: 16'h0000, irq: 1'b0};
        vecs[4] = '{sw: 16'h0000, chg: 16'hA5A5, w1c: 16'h5A5A, chg_after: 16'hA5A5, irq: 1'b1};
        vecs[5] = '{sw: 16'hFFFF, chg: 16'hFFFF, w1c: 16'hFF0F, chg_after: 16'h00F0, irq: 1'b1};

        tick(1);

        // Reset state.
        do_reset();
        check("reset_irq", {31'd0, o_irq}, 32'd0);
        rd(A_STATE,   32'd0, "reset_state");
        rd(A_CHANGED, 32'd0, "reset_changed");
        rd(A_IRQ_EN,  32'd0, "reset_irq_en");
        rd(A_RAW,     32'd0, "reset_raw");

        // Reset during a request drops the ack. A fresh cycle then works.
        wr(A_IRQ_EN, 32'h0000_00FF);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_adr = A_STATE;
        rst_core = 1'b1;
        tick(1);
        check("ack_in_reset", {31'd0, o_wb_ack}, 32'd0);
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        tick(1);
        rst_core = 1'b0;
        rd(A_IRQ_EN, 32'd0, "irq_en_after_midreset");

        // Input-to-register latency at the boundary cycles.
        probe(16'h8001, 1, A_RAW, 32'h0000_0000, "raw_before_2cyc");
        probe(16'h8001, 2, A_RAW, 32'h0000_8001, "raw_at_2cyc");
`ifdef VEERWOLF_SW_DEBOUNCE_EN
        // sync lands 2 cycles after the step. state then needs 9..12 more.
        probe(16'h0005, 10, A_STATE,   32'h0000_0000, "state_not_before_11");
        probe(16'h0005, 10, A_CHANGED, 32'h0000_0000, "changed_not_before_11");
        probe(16'h0005, 14, A_STATE,   32'h0000_0005, "state_within_14");
        probe(16'h0005, 14, A_CHANGED, 32'h0000_0005, "changed_within_14");
`else
        probe(16'h8001, 2, A_STATE,   32'h0000_0000, "state_before_3cyc");
        probe(16'h8001, 2, A_CHANGED, 32'h0000_0000, "changed_before_3cyc");
        probe(16'h8001, 3, A_STATE,   32'h0000_8001, "state_at_3cyc");
        probe(16'h8001, 3, A_CHANGED, 32'h0000_8001, "changed_at_3cyc");
`endif

        // A 6-cycle pulse on bit 3.
        do_reset();
        i_sw = 16'h0008;
        tick(6);
        i_sw = 16'h0000;
        tick(30);
        rd(A_STATE, 32'd0, "glitch_state");
`ifdef VEERWOLF_SW_DEBOUNCE_EN
        rd(A_CHANGED, 32'h0000_0000, "glitch_changed");
`else
        rd(A_CHANGED, 32'h0000_0008, "glitch_changed");
`endif

        // Interrupt raise, W1C clear, and a masked bit.
        do_reset();
        wr(A_IRQ_EN, 32'h0000_0004);
        rd(A_IRQ_EN, 32'h0000_0004, "irq_en_rw");
        i_sw = 16'h0004;
`ifdef VEERWOLF_SW_DEBOUNCE_EN
        poll_irq(n);
        check("irq_raised", {31'd0, (n != 0)}, 32'd1);
`else
        tick(3);
        check("irq_low_when_changed_sets", {31'd0, o_irq}, 32'd0);
        tick(1);
        check("irq_one_after_changed", {31'd0, o_irq}, 32'd1);
`endif
        rd(A_CHANGED, 32'h0000_0004, "irq_changed");
        wr(A_CHANGED, 32'h0000_0004);
        check("irq_still_at_ack", {31'd0, irq_at_ack}, 32'd1);
        check("irq_clear_after_w1c", {31'd0, o_irq}, 32'd0);
        i_sw = 16'h0005;
        tick(SETTLE);
        check("irq_masked_bit", {31'd0, o_irq}, 32'd0);
        rd(A_CHANGED, 32'h0000_0001, "masked_changed");

        // Set/clear collision: measure the bit-1 toggle edge, then repeat
        // from reset with a W1C write whose ack lands on that edge.
        do_reset();
        i_sw = 16'h0020;
        tick(SETTLE);
        wr(A_IRQ_EN, 32'h0000_0002);
        i_sw = 16'h0022;
        poll_irq(n);
        check("coll_toggle_seen", {31'd0, (n >= 2)}, 32'd1);
`ifndef VEERWOLF_SW_DEBOUNCE_EN
        check("coll_toggle_cycle", n, 32'd4);
`endif
        if (n >= 2) begin
            do_reset();
            i_sw = 16'h0020;
            tick(SETTLE);
            wr(A_IRQ_EN, 32'h0000_0002);
            i_sw = 16'h0022;
            tick(n - 2);
            wr(A_CHANGED, 32'h0000_FFFF);
            rd(A_CHANGED, 32'h0000_0002, "coll_set_wins");
            rd(A_STATE,   32'h0000_0022, "coll_state");
        end

        // Table-driven sweep of state, raw, sticky flags, W1C, and the mask.
        do_reset();
        wr(A_IRQ_EN, 32'h0000_00F0);
        for (int v = 0; v < 6; v++) begin
            i_sw = vecs[v].sw;
            tick(SETTLE);
            rd(A_STATE,   {16'd0, vecs[v].sw},  "tbl_state");
            rd(A_RAW,     {16'd0, vecs[v].sw},  "tbl_raw");
            rd(A_CHANGED, {16'd0, vecs[v].chg}, "tbl_changed");
            wr(A_CHANGED, {16'hFFFF, vecs[v].w1c});
            rd(A_CHANGED, {16'd0, vecs[v].chg_after}, "tbl_changed_after_w1c");
            check("tbl_irq", {31'd0, o_irq}, {31'd0, vecs[v].irq});
        end
        bus(1'b0, A_IRQ_EN, 32'd0, d);
        check("tbl_irq_en_upper_zero", d, 32'h0000_00F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
